// File: rtl/freq_meter_if.sv
// Result bus from freq_meter to the display/debug logic: registered period
// and gate-window edge count, each with a one-cycle valid strobe, plus the
// sticky timeout flag.
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             timeout;

  modport master (
    output period_out,
    output period_valid,
    output edge_count,
    output count_valid,
    output timeout
  );

  modport slave (
    input period_out,
    input period_valid,
    input edge_count,
    input count_valid,
    input timeout
  );
endinterface

// File: rtl/freq_meter.sv
// Frequency meter for a slow asynchronous square wave. Measures the clk
// distance between consecutive rising edges and counts rising edges over a
// free-running gate window. All results are registered.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int MAX_PERIOD  = 16777215,
  parameter int CNT_W       = 32
) (
  input  logic          clk_100MHz,
  input  logic          rst,
  input  logic          sig_in,
  freq_meter_if.master  res
);

  localparam int               GC_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PC_MAX    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] pc;
  logic             armed;
  logic [GC_W-1:0]  gc;
  logic [CNT_W-1:0] ea;
  logic [CNT_W-1:0] ea_inc;

  assign rise = s2 & ~s3;

  // Two-flop synchronizer for sig_in plus a history flop for edge detection.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Accumulator plus this cycle's rise, held at all-ones instead of wrapping.
  always_comb begin
    ea_inc = ea;
    if (rise && (ea != CNT_SAT)) begin
      ea_inc = ea + CNT_W'(1);
    end
  end

  // Period measurement: the counter restarts on every rise, so pc + 1 at the
  // next rise is the exact distance; saturation disarms and flags timeout.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      pc               <= '0;
      armed            <= 1'b0;
      res.period_out   <= '0;
      res.period_valid <= 1'b0;
      res.timeout      <= 1'b0;
    end else begin
      res.period_valid <= 1'b0;
      if (rise) begin
        pc          <= '0;
        armed       <= 1'b1;
        res.timeout <= 1'b0;
        if (armed) begin
          res.period_out   <= pc + CNT_W'(1);
          res.period_valid <= 1'b1;
        end
      end else if (pc == PC_MAX) begin
        res.timeout <= 1'b1;
        armed       <= 1'b0;
      end else begin
        pc <= pc + CNT_W'(1);
      end
    end
  end

  // Gate window: free-running counter; a rise in the terminal cycle is
  // folded into the closing window's result and the next window starts at 0.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      gc              <= '0;
      ea              <= '0;
      res.edge_count  <= '0;
      res.count_valid <= 1'b0;
    end else begin
      res.count_valid <= 1'b0;
      if (gc == GATE_LAST) begin
        gc              <= '0;
        ea              <= '0;
        res.edge_count  <= ea_inc;
        res.count_valid <= 1'b1;
      end else begin
        gc <= gc + GC_W'(1);
        ea <= ea_inc;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a stimulus-side model pushes expected
// period strobes into a queue and tallies rises per gate window; a monitor
// on the falling clock edge pops and compares whenever the DUT strobes.
module tb_freq_meter;

  localparam int GATE_CYCLES = 1000;
  localparam int MAX_PERIOD  = 4095;
  localparam int CNT_W       = 32;

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  logic clk_100MHz = 1'b0;
  logic rst;
  logic sig_in;

  freq_meter_if #(.CNT_W(CNT_W)) res_if ();

  freq_meter #(
    .GATE_CYCLES (GATE_CYCLES),
    .MAX_PERIOD  (MAX_PERIOD),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .sig_in     (sig_in),
    .res        (res_if)
  );

  longint cyc = 0;
  longint e0 = 0;
  longint last_rise_edge = 0;
  bit     model_armed = 1'b0;
  int     n_tests = 0;
  int     n_fails = 0;
  int     n_count = 0;
  int     win_cnt[longint];
  exp_t   period_q[$];
  exp_t   mon_e;
  longint mon_idx;
  longint mon_exp;

  // Free-running 100 MHz clock
  always #5 clk_100MHz = ~clk_100MHz;

  // Number of rising edges seen so far, stable at every falling edge
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Model of one synchronized rise: sig_in driven high after edge drv is
  // consumed by the DUT at edge drv+3.
  task automatic modelRise(input longint drv);
    longint re;
    longint idx;
    exp_t   e;
    re = drv + 3;
    if (model_armed && ((re - last_rise_edge) <= longint'(MAX_PERIOD) + 1)) begin
      e.val = re - last_rise_edge;
      e.cyc = re;
      period_q.push_back(e);
    end
    model_armed    = 1'b1;
    last_rise_edge = re;
    idx = (re - e0 - 1) / GATE_CYCLES;
    if (win_cnt.exists(idx)) win_cnt[idx] = win_cnt[idx] + 1;
    else win_cnt[idx] = 1;
  endtask

  // Drive a level, then hold it for a number of clocks (cursor: negedge + 1)
  task automatic applyStimulus(input logic level, input int cycles);
    if (level && !sig_in) modelRise(cyc);
    sig_in = level;
    repeat (cycles) begin
      @(negedge clk_100MHz);
      #1;
    end
  endtask

  task automatic idle_until(input longint n);
    while (cyc < n) begin
      @(negedge clk_100MHz);
      #1;
    end
  endtask

  task automatic square_wave(input int half, input int n);
    repeat (n) begin
      applyStimulus(1'b1, half);
      applyStimulus(1'b0, half);
    end
  endtask

  // One-cycle reset, then restart the model and check every output is 0
  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk_100MHz);
    #1;
    rst = 1'b0;
    e0          = cyc;
    model_armed = 1'b0;
    period_q.delete();
    win_cnt.delete();
    n_count = 0;
    checkOutput("rst_period_out", res_if.period_out, 0);
    checkOutput("rst_period_valid", res_if.period_valid, 0);
    checkOutput("rst_edge_count", res_if.edge_count, 0);
    checkOutput("rst_count_valid", res_if.count_valid, 0);
    checkOutput("rst_timeout", res_if.timeout, 0);
    if (sig_in) modelRise(e0);
  endtask

  // Scoreboard monitor: compare every strobe against the model
  always @(negedge clk_100MHz) begin
    while (period_q.size() > 0 && period_q[0].cyc < cyc) begin
      checkOutput("period_missing", cyc, period_q[0].cyc);
      void'(period_q.pop_front());
    end
    if (res_if.period_valid) begin
      if (period_q.size() == 0) begin
        checkOutput("period_unexpected", res_if.period_valid, 0);
      end else begin
        mon_e = period_q.pop_front();
        checkOutput("period_out", res_if.period_out, mon_e.val);
        checkOutput("period_time", cyc, mon_e.cyc);
      end
    end
    if (res_if.count_valid) begin
      checkOutput("count_phase", (cyc - e0) % GATE_CYCLES, 0);
      mon_idx = (cyc - e0) / GATE_CYCLES - 1;
      mon_exp = win_cnt.exists(mon_idx) ? longint'(win_cnt[mon_idx]) : 0;
      checkOutput("edge_count", res_if.edge_count, mon_exp);
      n_count++;
    end
  end

  // Hard stop in case the run ever stalls
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    longint r;
    longint r2;
    longint b;
    sig_in = 1'b0;
    rst    = 1'b1;
    reset_dut();

    // Square wave, period 100
    square_wave(50, 25);
    checkOutput("sq100_period", res_if.period_out, 100);
    checkOutput("sq100_count", res_if.edge_count, 10);

    // Toggle every clock, period 2
    square_wave(1, 1000);
    checkOutput("fast_period", res_if.period_out, 2);
    checkOutput("fast_count", res_if.edge_count, 500);
    checkOutput("fast_timeout", res_if.timeout, 0);

    // Hold low after one rise until timeout, then recover
    r = cyc;
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 1);
    idle_until(r + 3 + MAX_PERIOD);
    checkOutput("timeout_early", res_if.timeout, 0);
    idle_until(r + 3 + MAX_PERIOD + 1);
    checkOutput("timeout_set", res_if.timeout, 1);
    checkOutput("timeout_period_hold", res_if.period_out, 2);
    idle_until(r + 5000);
    checkOutput("timeout_sticky", res_if.timeout, 1);
    r2 = cyc;
    applyStimulus(1'b1, 3);
    checkOutput("timeout_clear", res_if.timeout, 0);
    checkOutput("rearm_no_strobe", res_if.period_valid, 0);
    applyStimulus(1'b1, 47);
    applyStimulus(1'b0, 250);
    checkOutput("rearm_gap", cyc - r2, 300);
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 20);
    checkOutput("after_timeout_period", res_if.period_out, 300);

    // Rise landing exactly in the gate terminal cycle
    b = e0 + longint'(GATE_CYCLES) * ((cyc - e0) / GATE_CYCLES + 2);
    idle_until(b - 3);
    applyStimulus(1'b1, 3);
    checkOutput("term_valid", res_if.count_valid, 1);
    checkOutput("term_count", res_if.edge_count, 1);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    idle_until(b + 497);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 1);
    idle_until(b + GATE_CYCLES);
    checkOutput("next_win_valid", res_if.count_valid, 1);
    checkOutput("next_win_count", res_if.edge_count, 1);

    // Reset in the middle of a low half-period
    square_wave(50, 3);
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 20);
    reset_dut();
    applyStimulus(1'b0, 29);
    square_wave(50, 3);
    checkOutput("post_rst_period", res_if.period_out, 100);

    // Irregular intervals 37, 250, 1023
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 27);
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 150);
    applyStimulus(1'b1, 500);
    applyStimulus(1'b0, 523);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 20);
    checkOutput("irregular_last", res_if.period_out, 1023);

    applyStimulus(1'b0, 10);
    checkOutput("period_pending", period_q.size(), 0);
    checkOutput("count_strobes", n_count, (cyc - e0) / GATE_CYCLES);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures a slow, asynchronous square-wave input on the fast system clock: period in clk cycles between consecutive rising edges, and rising-edge count over a fixed gate window.
- Receiving end of the divided/slow clocks the design generates: a bench and on-board self-check that slow_clk outputs or external pulse sources run at the intended rate.
- Results go to the display/debug logic as registered values with one-cycle valid strobes.

Parameters:
- GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz); must be >= 2.
- MAX_PERIOD, 16777215, period counter saturation value; reaching it flags timeout.
- CNT_W, 32, width of period_out and edge_count; must satisfy MAX_PERIOD < 2^CNT_W.

Ports:
- clk_100MHz  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous measured signal.
- period_out  output  CNT_W  last measured period in clk cycles.
- period_valid  output  1  one-cycle strobe: period_out updated this cycle.
- edge_count  output  CNT_W  rising edges counted in last completed gate window.
- count_valid  output  1  one-cycle strobe: edge_count updated this cycle.
- timeout  output  1  no rising edge for MAX_PERIOD cycles; sticky until next rising edge.

Behaviour:
- Reset (sync, active-high): all outputs 0; synchronizer flops, period counter, gate counter, edge accumulator 0; armed = 0. Reset overrides any event in the same cycle; a measurement in flight is discarded.
- Input path: 2-flop synchronizer s1, s2, plus history flop s3. rise = s2 & ~s3. Only rise edges are used; sig_in high for less than one clk period may be missed (acceptable).
- Latency: sig_in first sampled high at edge k -> rise true between edges k+1 and k+2 -> period_valid / accumulator update registered at edge k+2.
- Period counter pc:
  - On rise: pc <= 0.
  - Otherwise: pc <= pc + 1, saturating at MAX_PERIOD.
- Period result:
  - On rise with armed = 1: period_out <= pc + 1 and period_valid <= 1. This equals the exact cycle distance between the two rises.
  - On every rise: armed <= 1 and timeout <= 0.
  - The first rise after reset, or after a timeout, only arms; it produces no valid strobe.
- Timeout: when pc = MAX_PERIOD and no rise occurs, timeout <= 1 and armed <= 0. It stays 1 until the next rise. period_out holds its previous value throughout.
- Gate window:
  - Gate counter gc runs 0 .. GATE_CYCLES-1 and wraps, free-running from reset.
  - Edge accumulator ea increments on rise, saturating at 2^CNT_W-1.
  - Terminal cycle (gc = GATE_CYCLES-1): edge_count <= ea + rise (saturating), count_valid <= 1, ea <= 0.
  - A rise coinciding with the terminal cycle belongs to the closing window.
- Strobes are one cycle wide. period_valid and count_valid may assert in the same cycle.
- Outputs are registered; no combinational path from sig_in to any output.

Test Plan:
- Use GATE_CYCLES=1000 and MAX_PERIOD=4095 for all scenarios.
- Reset release, then sig_in square wave with period 100 clk (50 high / 50 low): first rise gives no strobe; each later rise gives period_valid with period_out=100; each window gives count_valid with edge_count=10.
- sig_in toggling every clk (period 2): period_out=2 on every rise after the first; edge_count=500 per window; no timeout.
- sig_in held low 5000 cycles after one rise: timeout=1 exactly 4096 cycles after that rise, with period_out unchanged. Next rise clears timeout with no period_valid. A following rise 300 cycles later gives period_out=300.
- Rise timed into gate terminal cycle gc=999: counted in the closing window's edge_count; next window's accumulator starts at 0.
- rst asserted for 1 cycle mid-period (square wave period 100): all outputs 0 the next cycle; first post-reset rise gives no strobe; second gives period_out=100.
- Irregular periods 37, 250, 1023: period_out equals each interval exactly, strobe 2 cycles after each sig_in rise (synchronizer latency).
